// File: rtl/fp_pkg.sv
// fp_pkg: shared types and helpers for the floating-point datapath
// (multiplier today, adder later).
package fp_pkg;

    // operand classification (subnormals are recognised, then flushed to zero)
    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // special-result code carried down the pipe alongside the datapath
    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } fp_special_e;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_W         = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // canonical quiet NaN {0, all-ones exponent, 1 followed by zeros}, right-aligned
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round / pack / flag stage.
// Takes a signed biased exponent and a raw (MAN_W+1)x(MAN_W+1) mantissa
// product of two normal operands, or a precomputed special-result code.
// Build option FP_MUL_RNE_EN: defined -> round-to-nearest-even and overflow
// to infinity; undefined -> truncation and overflow saturating to the
// largest finite value of the result sign.
module fp_round_pack import fp_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic                   i_sign,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [2*MAN_W+1:0]     i_prod,
    input  fp_special_e            i_special,
    output logic [W-1:0]           o_result,
    output logic [FLAG_W-1:0]      o_flags
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [W-1:0]          QNAN    = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0]  EXP_MAX = EW'((1 << EXP_W) - 1);

    logic                  w_top;
    logic [PW-2:0]         w_norm;
    logic [MAN_W-1:0]      w_frac;
    logic [MAN_W-1:0]      w_frac_r;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inexact;
    logic signed [EW-1:0]  w_exp_n;
    logic signed [EW-1:0]  w_exp_r;
    logic                  w_exp_le0;

    // product is in [1,4): when bit PW-1 is set the value is >= 2, so the
    // window moves up one place and the exponent gains one; the leading one
    // itself is dropped from the normalised vector
    assign w_top     = i_prod[PW-1];
    assign w_norm    = w_top ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
    assign w_frac    = w_norm[PW-2 -: MAN_W];
    assign w_guard   = w_norm[MAN_W];
    assign w_sticky  = |w_norm[MAN_W-1:0];
    assign w_inexact = w_guard | w_sticky;
    assign w_exp_n   = i_exp + $signed({{(EW-1){1'b0}}, w_top});

`ifdef FP_MUL_RNE_EN
    logic w_round_up;
    logic w_carry;

    // an all-ones fraction that rounds up wraps to zero and bumps the exponent
    assign w_round_up = w_guard & (w_sticky | w_frac[0]);
    assign w_carry    = w_round_up & (&w_frac);
    assign w_frac_r   = w_frac + MAN_W'(w_round_up);
    assign w_exp_r    = w_exp_n + $signed({{(EW-1){1'b0}}, w_carry});
`else
    assign w_frac_r   = w_frac;
    assign w_exp_r    = w_exp_n;
`endif

    assign w_exp_le0 = w_exp_r[EW-1] | (w_exp_r == '0);

    // select special result, overflow/underflow result or the packed value
    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_special)
            SP_NAN: begin
                o_result               = QNAN;
                o_flags[FLAG_INVALID]  = 1'b1;
            end
            SP_INF: begin
                o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            SP_ZERO: begin
                o_result = {i_sign, {(W-1){1'b0}}};
            end
            default: begin
                if (w_exp_r >= EXP_MAX) begin
`ifdef FP_MUL_RNE_EN
                    o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
                    o_result = {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
                    o_flags[FLAG_OVERFLOW] = 1'b1;
                    o_flags[FLAG_INEXACT]  = 1'b1;
                end else if (w_exp_le0) begin
                    // both operands are normal here, so the exact product is never zero
                    o_result                = {i_sign, {(W-1){1'b0}}};
                    o_flags[FLAG_UNDERFLOW] = 1'b1;
                    o_flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    o_result              = {i_sign, w_exp_r[EXP_W-1:0], w_frac_r};
                    o_flags[FLAG_INEXACT] = w_inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with a
// valid/ready stream interface. S1 classifies and sums exponents, S2 forms
// the mantissa product, S3 registers the normalised/rounded/packed result.
// Build option FP_MUL_RNE_EN selects round-to-nearest-even (defined) or
// truncation with overflow saturation (undefined, default).
module fp_mul_pipe import fp_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] input1,
    input  logic [W-1:0] input2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] output1,
    output logic [3:0]   flags
);

    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(fp_bias(EXP_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return (f == '0) ? FP_ZERO : FP_SUB;
        end else if (&e) begin
            return (f == '0) ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

    logic                  w_advance;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [EXP_W-1:0]      w_exp_a;
    logic [EXP_W-1:0]      w_exp_b;
    logic [MAN_W-1:0]      w_frac_a;
    logic [MAN_W-1:0]      w_frac_b;
    fp_class_e             w_cls_a;
    fp_class_e             w_cls_b;
    fp_special_e           w_special;
    logic signed [EW-1:0]  w_exp_sum;
    logic [PW-1:0]         w_prod;
    logic [W-1:0]          w_rp_result;
    logic [FLAG_W-1:0]     w_rp_flags;

    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic signed [EW-1:0]  r_s1_exp;
    logic [MAN_W:0]        r_s1_man_a;
    logic [MAN_W:0]        r_s1_man_b;
    fp_special_e           r_s1_special;

    logic                  r_s2_valid;
    logic                  r_s2_sign;
    logic signed [EW-1:0]  r_s2_exp;
    logic [PW-1:0]         r_s2_prod;
    fp_special_e           r_s2_special;

    logic                  r_s3_valid;
    logic [W-1:0]          r_result;
    logic [FLAG_W-1:0]     r_flags;

    // the whole pipe moves together; a stalled output freezes every stage
    assign w_advance = out_ready | ~r_s3_valid;
    assign in_ready  = w_advance;
    assign out_valid = r_s3_valid;
    assign output1   = r_result;
    assign flags     = r_flags;

    assign w_sign_a  = input1[W-1];
    assign w_sign_b  = input2[W-1];
    assign w_exp_a   = input1[W-2 -: EXP_W];
    assign w_exp_b   = input2[W-2 -: EXP_W];
    assign w_frac_a  = input1[MAN_W-1:0];
    assign w_frac_b  = input2[MAN_W-1:0];
    assign w_cls_a   = classify(w_exp_a, w_frac_a);
    assign w_cls_b   = classify(w_exp_b, w_frac_b);
    assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - BIAS_S;
    assign w_prod    = {{(MAN_W+1){1'b0}}, r_s1_man_a} * {{(MAN_W+1){1'b0}}, r_s1_man_b};

    // S1 special-result priority: NaN / inf*zero, then inf, then zero (subnormals flushed)
    always_comb begin
        logic zero_a;
        logic zero_b;
        zero_a    = (w_cls_a == FP_ZERO) || (w_cls_a == FP_SUB);
        zero_b    = (w_cls_b == FP_ZERO) || (w_cls_b == FP_SUB);
        w_special = SP_NONE;
        if ((w_cls_a == FP_NAN) || (w_cls_b == FP_NAN) ||
            ((w_cls_a == FP_INF) && zero_b) || ((w_cls_b == FP_INF) && zero_a)) begin
            w_special = SP_NAN;
        end else if ((w_cls_a == FP_INF) || (w_cls_b == FP_INF)) begin
            w_special = SP_INF;
        end else if (zero_a || zero_b) begin
            w_special = SP_ZERO;
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .i_sign    (r_s2_sign),
        .i_exp     (r_s2_exp),
        .i_prod    (r_s2_prod),
        .i_special (r_s2_special),
        .o_result  (w_rp_result),
        .o_flags   (w_rp_flags)
    );

    // stage valid bits and registered outputs; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_result <= w_rp_result;
                r_flags  <= w_rp_flags;
            end
        end
    end

    // stage payloads, qualified by the valid bits so no reset is needed
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_s1_sign    <= w_sign_a ^ w_sign_b;
            r_s1_exp     <= w_exp_sum;
            r_s1_man_a   <= {1'b1, w_frac_a};
            r_s1_man_b   <= {1'b1, w_frac_b};
            r_s1_special <= w_special;
            r_s2_sign    <= r_s1_sign;
            r_s2_exp     <= r_s1_exp;
            r_s2_prod    <= w_prod;
            r_s2_special <= r_s1_special;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed vectors for the single-precision configuration,
// an arithmetic reference model feeding an in-order scoreboard, and
// handshake / stall-stability checks on every cycle.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output1;
    logic [3:0]  flags;

    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_results = 0;
    logic        bp_en     = 1'b0;
    logic [35:0] sb_q[$];

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] OVF_RES = 32'h7F800000;
`else
    localparam logic [31:0] OVF_RES = 32'h7F7FFFFF;
`endif

    fp_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output1   (output1),
        .flags     (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [35:0] act, input logic [35:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // reference: exact integer product, then scale by division and round on the remainder
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e;
        longint ma, mb, p, q, r, div, half;
        logic   nan_a, nan_b, inf_a, inf_b, z_a, z_b, inexact;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        z_a   = (ea == 0);
        z_b   = (eb == 0);
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) return {4'b1000, 32'h7FC00000};
        if (inf_a || inf_b) return {4'b0000, s, 8'hFF, 23'h0};
        if (z_a || z_b) return {4'b0000, s, 31'h0};
        ma = (longint'(1) << 23) + longint'(a[22:0]);
        mb = (longint'(1) << 23) + longint'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            div = longint'(1) << 24;
            e   = e + 1;
        end else begin
            div = longint'(1) << 23;
        end
        q       = p / div;
        r       = p % div;
        half    = div / 2;
        inexact = (r != 0);
`ifdef FP_MUL_RNE_EN
        if ((r > half) || ((r == half) && (q % 2 == 1))) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = q / 2;
            e = e + 1;
        end
`endif
        if (e >= 255) begin
`ifdef FP_MUL_RNE_EN
            return {4'b0101, s, 8'hFF, 23'h0};
`else
            return {4'b0101, s, 8'hFE, 23'h7FFFFF};
`endif
        end
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), 23'(q - (longint'(1) << 23))};
    endfunction

    // out_ready: held high, or cycling 1,0,0,1 while backpressure is enabled
    initial begin
        logic [3:0] pat;
        int         ph;
        pat       = 4'b1001;
        ph        = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = pat[ph % 4];
                ph++;
            end else begin
                out_ready = 1'b1;
                ph        = 0;
            end
        end
    end

    // scoreboard and per-cycle handshake checks, sampled mid-cycle
    initial begin
        logic        stall_prev;
        logic [35:0] prev_out;
        logic [35:0] exp_v;
        stall_prev = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                check("in_ready_rule", 36'(in_ready), 36'(!(out_valid && !out_ready)));
                if (stall_prev) begin
                    check("stall_valid_held", 36'(out_valid), 36'd1);
                    check("stall_data_held", {flags, output1}, prev_out);
                end
                if (out_valid && out_ready) begin
                    n_results++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result actual=%h required=none", {flags, output1});
                    end else begin
                        exp_v = sb_q.pop_front();
                        check("model_result", {flags, output1}, exp_v);
                    end
                end
                if (in_valid && in_ready) sb_q.push_back(model(input1, input2));
                stall_prev = out_valid && !out_ready;
                prev_out   = {flags, output1};
            end
        end
    end

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int   c;
        logic got;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        c        = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
        end else begin
            check({name, "_latency"}, 36'(cyc - c), 36'd3);
            check({name, "_result"}, 36'(output1), 36'(exp_res));
            check({name, "_flags"}, 36'(flags), 36'(exp_flags));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        acc;
        int          r0;

        va = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'hC0A00000,
               32'h3F800001, 32'h3FFFFFFF, 32'h7F000000, 32'h00000000};
        vb = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3E800000,
               32'h3F7FFFFF, 32'h3FFFFFFF, 32'h3F800001, 32'h7F800000};

        rst      = 1'b1;
        in_valid = 1'b0;
        input1   = '0;
        input2   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 36'(out_valid), 36'd0);
        check("reset_output1", 36'(output1), 36'd0);
        check("reset_flags", 36'(flags), 36'd0);
        check("reset_in_ready", 36'(in_ready), 36'd1);

        run_one("basic_pos", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_one("basic_neg", 32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
        run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_one("negzero_x_one", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        run_one("nan_x_one", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_one("overflow", 32'h7F000000, 32'h7F000000, OVF_RES, 4'b0101);
        run_one("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        run_one("round_small", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_one("round_large", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
        run_one("subnormal_flush", 32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000);

        // back-to-back stream under 1,0,0,1 backpressure
        @(posedge clk);
        #1;
        bp_en = 1'b1;
        r0    = n_results;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            input1   = va[i];
            input2   = vb[i];
            acc      = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_checks++;
                n_errors++;
                $display("FAIL stream_accept_%0d actual=never_ready required=accepted", i);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge clk);
        check("stream_drained", 36'(sb_q.size()), 36'd0);
        check("stream_count", 36'(n_results - r0), 36'd8);
        @(posedge clk);
        #1;
        bp_en = 1'b0;
        repeat (2) @(posedge clk);

        // reset with three operations in flight
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            input1   = va[i];
            input2   = vb[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 36'(out_valid), 36'd0);
        check("midreset_output1", 36'(output1), 36'd0);
        check("midreset_flags", 36'(flags), 36'd0);
        run_one("post_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        repeat (4) @(negedge clk);
        check("final_queue_empty", 36'(sb_q.size()), 36'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the single-format integration multiplier.
- Adds generic exponent/mantissa widths, biased exponents, special-value handling, round-to-nearest-even, exception flags, and a valid/ready stream interface with backpressure.
- Sits between operand-issue logic and the result writeback path of the FP datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden leading one).
- W, 1+EXP_W+MAN_W, total word width (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operand pair this cycle.
- input1  in  W  operand A {sign, exp, frac}.
- input2  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- output1  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid.

Behaviour:
- Reset (rst=1 at posedge): all stage valid bits cleared; out_valid=0, output1=0, flags=0. in_ready=1 in the cycle after reset. In-flight data is discarded; reset wins over any simultaneous handshake.
- Pipeline: 3 registered stages, latency 3 cycles from an accepted input to out_valid with no stall.
  - S1: classify operands (zero, subnormal, inf, NaN, normal); sign = sA^sB; exponent sum eA+eB-BIAS in EXP_W+2 signed bits. BIAS = 2^(EXP_W-1)-1.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits.
  - S3: normalise (shift right 1 and exp+1 if product MSB set), round, pack, set flags.
- Flow control:
  - advance = out_ready | ~out_valid; in_ready = advance.
  - When advance=0, every stage holds. Internal bubbles are not compressed.
  - output1 and flags are stable while out_valid=1 and out_ready=0.
- Rounding: round-to-nearest-even on guard/sticky bits. Mantissa carry-out on rounding renormalises and increments the exponent.
- Special cases, in priority order:
  - Any NaN, or inf x zero -> canonical qNaN {0, all-ones exp, 1 followed by zeros}; invalid=1.
  - inf x finite-nonzero -> signed inf.
  - zero x finite -> signed zero.
  - Subnormal inputs are treated as zero (flush-to-zero).
- Overflow: biased result exponent >= 2^EXP_W-1 after rounding -> signed inf; overflow=1, inexact=1.
- Underflow: biased result exponent <= 0 -> signed zero; underflow=1, inexact=1 unless the exact product is zero.
- inexact=1 whenever discarded bits are nonzero.
- Throughput: 1 result per cycle when out_ready is held high.

Optional Feature:
- Macro: FP_MUL_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncation (round toward zero). No rounding incrementer; inexact is still reported. On overflow the result saturates to the max finite value of that sign instead of inf.

Decomposition:
- Shared package fp_pkg holds:
  - class enum {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_NAN};
  - flag bit index constants;
  - a BIAS function of EXP_W;
  - a canonical-qNaN constant function.
- One sub-module: fp_round_pack (S3 normalise/round/pack/flags, combinational). It is reused later by the adder.

Test Plan:
- Basic: 0x3FC00000 x 0x40000000 -> 0x40400000, flags 0, out_valid exactly 3 cycles after acceptance. Repeat with 0xBFC00000 -> 0xC0400000.
- Specials:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
  - 0x80000000 x 0x3F800000 -> 0x80000000, flags 0.
  - 0x7FC00001 x 0x3F800000 -> 0x7FC00000, invalid=1.
- Overflow/underflow:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1 (0x7F7FFFFF without FP_MUL_RNE_EN).
  - 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1. Also 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE, inexact=1.
- Backpressure:
  - Stream 8 operand pairs back-to-back with out_ready toggling 1,0,0,1 repeating.
  - All 8 results arrive in order, none lost or duplicated.
  - in_ready is low exactly when out_valid=1 and out_ready=0.
  - output1 is stable during stalls.
- Reset mid-stream: assert rst for 1 cycle while 3 operations are in flight -> out_valid=0 the next cycle. No stale result ever appears; the next accepted pair yields its correct result after 3 cycles.
